// File: rtl/m8_frame_checker.sv
// m8_frame_checker: M8 frame synchroniser (HUNT/CHECK/LOCK) with frame, sequence and sync error counters.
// Define M8_FILL_CHECK_EN to count corrupted fill words while locked; otherwise fillErrCnt is tied to 0.
module m8_frame_checker #(
    parameter int FRAME_LEN  = 1024,
    parameter int CONFIRM    = 2,
    parameter int MISS_LIMIT = 2
) (
    input  logic        reset,
    input  logic        clk,
    input  logic        wordValid,
    input  logic [11:0] wordIn,
    output logic        locked,
    output logic        frameStb,
    output logic [7:0]  markerCounter,
    output logic [15:0] frameCnt,
    output logic [15:0] seqErrCnt,
    output logic [7:0]  syncErrCnt,
    output logic [15:0] fillErrCnt
);
    localparam int PW = $clog2(FRAME_LEN);
    localparam int CW = $clog2(CONFIRM + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [CW-1:0] confirm_q, confirm_d, confirm_inc;
    logic [MW-1:0] miss_q, miss_d, miss_inc;
    logic [7:0]    prev_q, prev_d, mcnt_q, mcnt_d, sync_q, sync_d;
    logic [15:0]   frame_q, frame_d, seq_q, seq_d;
    logic          locked_q, locked_d, stb_q, stb_d;
    logic          is_marker, at_zero, succ;
    logic [7:0]    cnt;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return &v ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat8(input logic [7:0] v);
        return &v ? v : v + 8'd1;
    endfunction

    assign cnt         = wordIn[10:3];
    assign is_marker   = !wordIn[11] && wordIn[2:0] == 3'b001;
    assign at_zero     = pos_q == '0;
    assign succ        = cnt == prev_q + 8'd1;
    assign confirm_inc = confirm_q + 1'b1;
    assign miss_inc    = miss_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        confirm_d = confirm_q;
        miss_d    = miss_q;
        prev_d    = prev_q;
        mcnt_d    = mcnt_q;
        frame_d   = frame_q;
        seq_d     = seq_q;
        sync_d    = sync_q;
        stb_d     = 1'b0;
        if (wordValid) begin
            pos_d = pos_q + 1'b1;
            case (state_q)
                HUNT: begin
                    // Any marker is a candidate; it becomes position 0 of the assumed frame.
                    if (is_marker) begin
                        prev_d    = cnt;
                        pos_d     = PW'(1);
                        confirm_d = '0;
                        state_d   = CHECK;
                    end
                end
                CHECK: begin
                    if (at_zero) begin
                        if (is_marker && succ) begin
                            prev_d    = cnt;
                            confirm_d = confirm_inc;
                            if (confirm_inc == CW'(CONFIRM)) begin
                                state_d = LOCK;
                                miss_d  = '0;
                                stb_d   = 1'b1;
                                mcnt_d  = cnt;
                                frame_d = sat16(frame_q);
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCK: begin
                    if (at_zero) begin
                        if (is_marker) begin
                            stb_d   = 1'b1;
                            frame_d = sat16(frame_q);
                            mcnt_d  = cnt;
                            prev_d  = cnt;
                            miss_d  = '0;
                            seq_d   = succ ? seq_q : sat16(seq_q);
                        end else begin
                            sync_d  = sat8(sync_q);
                            miss_d  = miss_inc;
                            state_d = miss_inc == MW'(MISS_LIMIT) ? HUNT : LOCK;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = state_d == LOCK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            pos_q     <= '0;
            confirm_q <= '0;
            miss_q    <= '0;
            prev_q    <= '0;
            mcnt_q    <= '0;
            frame_q   <= '0;
            seq_q     <= '0;
            sync_q    <= '0;
            locked_q  <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            confirm_q <= confirm_d;
            miss_q    <= miss_d;
            prev_q    <= prev_d;
            mcnt_q    <= mcnt_d;
            frame_q   <= frame_d;
            seq_q     <= seq_d;
            sync_q    <= sync_d;
            locked_q  <= locked_d;
            stb_q     <= stb_d;
        end
    end

`ifdef M8_FILL_CHECK_EN
    logic [15:0] fill_q, fill_d;

    always_comb begin
        fill_d = (wordValid && state_q == LOCK && !at_zero && wordIn != 12'h002) ? sat16(fill_q) : fill_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fillErrCnt = fill_q;
`else
    assign fillErrCnt = '0;
`endif

    assign locked        = locked_q;
    assign frameStb      = stb_q;
    assign markerCounter = mcnt_q;
    assign frameCnt      = frame_q;
    assign seqErrCnt     = seq_q;
    assign syncErrCnt    = sync_q;
endmodule

// File: tb/tb_m8_frame_checker.sv
// tb_m8_frame_checker: directed frames with a strobe scoreboard for m8_frame_checker.
module tb_m8_frame_checker;
    localparam int FRAME_LEN = 1024;
`ifdef M8_FILL_CHECK_EN
    localparam int FE = 1;
`else
    localparam int FE = 0;
`endif

    logic        reset, clk, wordValid;
    logic [11:0] wordIn;
    logic        locked, frameStb;
    logic [7:0]  markerCounter, syncErrCnt;
    logic [15:0] frameCnt, seqErrCnt, fillErrCnt;

    typedef struct packed {
        logic [7:0]  mc;
        logic [15:0] fc;
        logic [15:0] seq;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    m8_frame_checker #(.FRAME_LEN(FRAME_LEN), .CONFIRM(2), .MISS_LIMIT(2)) dut (
        .reset(reset), .clk(clk), .wordValid(wordValid), .wordIn(wordIn),
        .locked(locked), .frameStb(frameStb), .markerCounter(markerCounter),
        .frameCnt(frameCnt), .seqErrCnt(seqErrCnt), .syncErrCnt(syncErrCnt),
        .fillErrCnt(fillErrCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] mk(input logic [7:0] c);
        return {1'b0, c, 3'b001};
    endfunction

    task automatic send(input logic [11:0] w);
        wordValid = 1'b1;
        wordIn = w;
        @(posedge clk);
        #1;
        wordValid = 1'b0;
    endtask

    task automatic frame(input logic [11:0] w0, input int bad_pos, input logic [11:0] bad_w,
                         input logic acc, input logic [7:0] mc, input logic [15:0] fc,
                         input logic [15:0] seq, input logic lk);
        if (acc) q.push_back('{mc: mc, fc: fc, seq: seq});
        send(w0);
        chk("locked_after_word0", {15'd0, locked}, {15'd0, lk});
        for (int i = 1; i < FRAME_LEN; i++) begin
            if (i == 100) begin
                wordIn = 12'hFFF;
                repeat (2) @(posedge clk);
                #1;
            end
            send(i == bad_pos ? bad_w : 12'h002);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_locked"}, {15'd0, locked}, 16'd0);
        chk({tag, "_frameStb"}, {15'd0, frameStb}, 16'd0);
        chk({tag, "_markerCounter"}, {8'd0, markerCounter}, 16'd0);
        chk({tag, "_frameCnt"}, frameCnt, 16'd0);
        chk({tag, "_seqErrCnt"}, seqErrCnt, 16'd0);
        chk({tag, "_syncErrCnt"}, {8'd0, syncErrCnt}, 16'd0);
        chk({tag, "_fillErrCnt"}, fillErrCnt, 16'd0);
    endtask

    // Every accepted marker must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && frameStb) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL strobe_unexpected: got markerCounter=%0d frameCnt=%0d expected no strobe", markerCounter, frameCnt);
            end else begin
                e = q.pop_front();
                chk("strobe_markerCounter", {8'd0, markerCounter}, {8'd0, e.mc});
                chk("strobe_frameCnt", frameCnt, e.fc);
                chk("strobe_seqErrCnt", seqErrCnt, e.seq);
                chk("strobe_locked", {15'd0, locked}, 16'd1);
            end
        end
    end

    initial begin
        reset = 1'b0;
        wordValid = 1'b0;
        wordIn = '0;
        #12;
        chk_reset_state("por");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        frame(mk(8'd5), -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        frame(mk(8'd6), -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        frame(mk(8'd7), -1, 12'h0, 1'b1, 8'd7, 16'd1, 16'd0, 1'b1);
        frame(mk(8'd8), -1, 12'h0, 1'b1, 8'd8, 16'd2, 16'd0, 1'b1);
        frame(mk(8'd9), -1, 12'h0, 1'b1, 8'd9, 16'd3, 16'd0, 1'b1);
        frame(mk(8'd10), -1, 12'h0, 1'b1, 8'd10, 16'd4, 16'd0, 1'b1);
        frame(mk(8'd12), -1, 12'h0, 1'b1, 8'd12, 16'd5, 16'd1, 1'b1);
        frame(mk(8'd13), -1, 12'h0, 1'b1, 8'd13, 16'd6, 16'd1, 1'b1);
        frame(mk(8'd255), -1, 12'h0, 1'b1, 8'd255, 16'd7, 16'd2, 1'b1);
        frame(mk(8'd0), -1, 12'h0, 1'b1, 8'd0, 16'd8, 16'd2, 1'b1);
        frame(mk(8'd1), 297, 12'h0A2, 1'b1, 8'd1, 16'd9, 16'd2, 1'b1);
        chk("fill_after_0A2", fillErrCnt, 16'(FE));
        chk("locked_after_0A2", {15'd0, locked}, 16'd1);
        frame(mk(8'd2), 500, mk(8'd50), 1'b1, 8'd2, 16'd10, 16'd2, 1'b1);
        chk("fill_after_midmarker", fillErrCnt, 16'(2 * FE));
        chk("locked_after_midmarker", {15'd0, locked}, 16'd1);
        frame(12'h002, -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b1);
        chk("sync_one_miss", {8'd0, syncErrCnt}, 16'd1);
        frame(mk(8'd3), -1, 12'h0, 1'b1, 8'd3, 16'd11, 16'd2, 1'b1);
        frame(12'h002, -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b1);
        chk("sync_first_of_two", {8'd0, syncErrCnt}, 16'd2);
        frame(12'h002, -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        chk("sync_second_of_two", {8'd0, syncErrCnt}, 16'd3);
        frame(mk(8'd20), -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        frame(mk(8'd30), -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        frame(mk(8'd31), -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        frame(mk(8'd32), -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        frame(mk(8'd33), -1, 12'h0, 1'b1, 8'd33, 16'd12, 16'd2, 1'b1);
        q.push_back('{mc: 8'd34, fc: 16'd13, seq: 16'd2});
        send(mk(8'd34));
        for (int i = 1; i < 500; i++) send(12'h002);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_state("midframe");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        frame(mk(8'd40), -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        frame(mk(8'd41), -1, 12'h0, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0);
        frame(mk(8'd42), -1, 12'h0, 1'b1, 8'd42, 16'd1, 16'd0, 1'b1);
        chk("relock_sync", {8'd0, syncErrCnt}, 16'd0);
        chk("relock_fill", fillErrCnt, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 16'(q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/m8_frame_checker.md
M8_FRAME_CHECKER -- requirements
Module: m8_frame_checker

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024, words per frame (power of two, 16..1024).
REQ-002 SHALL have parameter CONFIRM, default 2, consecutive good successor markers needed to lock.
REQ-003 SHALL have parameter MISS_LIMIT, default 2, consecutive bad markers in LOCK that drop lock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-006 SHALL have port wordValid, input, 1 bit: wordIn is valid this cycle.
REQ-007 SHALL have port wordIn, input, 12 bits: received M8 word.
REQ-008 SHALL have port locked, output, 1 bit: frame sync achieved.
REQ-009 SHALL have port frameStb, output, 1 bit: one-cycle pulse per marker accepted in LOCK.
REQ-010 SHALL have port markerCounter, output, 8 bits: counter field of the last accepted marker.
REQ-011 SHALL have port frameCnt, output, 16 bits: markers accepted in LOCK.
REQ-012 SHALL have port seqErrCnt, output, 16 bits: marker counter discontinuities in LOCK.
REQ-013 SHALL have port syncErrCnt, output, 8 bits: bad markers seen in LOCK.
REQ-014 SHALL have port fillErrCnt, output, 16 bits: corrupted fill words (see Configuration).

Function
REQ-015 Marker word SHALL be defined as wordIn[11]==0 and wordIn[2:0]==3'b001; counter field is wordIn[10:3].
REQ-016 Fill word SHALL be defined as exactly 12'h002.
REQ-017 With wordValid low, no state, position or counter SHALL change, and frameStb SHALL be 0.
REQ-018 All outputs SHALL be registered; an input word sampled on edge N SHALL be reflected on the outputs after edge N.
REQ-019 The position counter SHALL advance by 1 per valid word and wrap from FRAME_LEN-1 to 0.
REQ-020 The FSM SHALL have three states: HUNT, CHECK and LOCK.
REQ-021 In HUNT, a marker SHALL store its counter as prev, set position to 1, clear confirm, and enter CHECK; non-markers SHALL be ignored.
REQ-022 In CHECK, at position 0, a marker with counter==prev+1 (mod 256) SHALL increment confirm and update prev; any other word SHALL return the FSM to HUNT without re-evaluating that word.
REQ-023 When confirm reaches CONFIRM, the FSM SHALL enter LOCK on that edge; that marker SHALL also count as accepted (frameStb pulse, frameCnt+1).
REQ-024 In LOCK, at position 0, a marker SHALL pulse frameStb, increment frameCnt, update markerCounter and prev, and clear miss.
REQ-025 In LOCK, a marker whose counter is not prev+1 SHALL increment seqErrCnt and SHALL NOT drop lock.
REQ-026 In LOCK, a non-marker at position 0 SHALL increment syncErrCnt and miss; when miss reaches MISS_LIMIT, the FSM SHALL enter HUNT and locked SHALL deassert; prev SHALL be kept.
REQ-027 The counter field wrap 255->0 SHALL be a valid successor.
REQ-028 Marker-pattern words at position!=0 SHALL never resynchronise the FSM.
REQ-029 All error/frame counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-030 locked SHALL be 1 exactly while the FSM is in LOCK.

Reset
REQ-031 On reset low, the FSM SHALL enter HUNT and position, confirm, miss, prev and all outputs SHALL be 0 immediately, including when reset is asserted mid-frame.
REQ-032 After reset release, the first valid word SHALL be treated as a HUNT candidate.

Configuration
REQ-033 When macro M8_FILL_CHECK_EN is defined, every valid word at position!=0 in LOCK that is not 12'h002 SHALL increment fillErrCnt.
REQ-034 When M8_FILL_CHECK_EN is undefined, fillErrCnt SHALL be constant 0 and the fill-compare logic SHALL be absent.

Verification
REQ-035 Reset: assert reset mid-frame in LOCK -> locked=0, all counters 0, frameStb=0; after release, the next clean frames relock normally.
REQ-036 Clean frames with markers 5, 6, 7 (1024 words each) -> locked rises after word 0 of frame 7, frameCnt=1, markerCounter=7; frames 8 and 9 -> frameCnt=3, seqErrCnt=0.
REQ-037 Locked, marker 255 then 0 -> seqErrCnt stays 0, markerCounter=0.
REQ-038 Locked, marker 10 then 12 -> seqErrCnt=1, locked stays 1, markerCounter=12.
REQ-039 Locked, two consecutive frames with word 0 = 12'h002 -> syncErrCnt=2, locked=0 after the second; one bad marker then a good one -> locked stays 1.
REQ-040 Locked, word 297 = 12'h0A2: with M8_FILL_CHECK_EN -> fillErrCnt=1; without -> fillErrCnt=0; in both cases locked stays 1.
